// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for button gesture consumers: state encodings, default
// timing parameters and the event-count width.
package button_press_classifier_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PRESSED     = 3'd1,
      ST_WAIT_GAP    = 3'd2,
      ST_SECOND_HELD = 3'd3,
      ST_LONG_HELD   = 3'd4
   } state_e;

   localparam int DEF_LONG_TICKS    = 8;
   localparam int DEF_DBL_GAP_TICKS = 4;
   localparam int EVT_CNT_W         = 8;

endpackage

// File: rtl/button_press_classifier_press_timer.sv
// Up-counter with synchronous clear (priority over enable) and a terminal flag
// raised when the count reaches term_val-1.
module press_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_val_i,
   output logic             term_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign term_o = (count_q == (term_val_i - ONE));

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short / double / long presses,
// emitting registered one-cycle pulses and a wrapping event count.
module button_press_classifier
   import button_press_classifier_pkg::*;
#(
   parameter int LONG_TICKS    = DEF_LONG_TICKS,
   parameter int DBL_GAP_TICKS = DEF_DBL_GAP_TICKS,
   parameter int CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_level,
   output logic                 short_press,
   output logic                 double_press,
   output logic                 long_press,
   output logic                 busy,
   output logic [EVT_CNT_W-1:0] event_cnt,
   output logic [2:0]           dbg_state
);

   state_e               state_q, state_d;
   logic                 prev_q;
   logic                 short_q, short_d;
   logic                 double_q, double_d;
   logic                 long_q, long_d;
   logic                 busy_q;
   logic [EVT_CNT_W-1:0] cnt_q, cnt_d;
   logic                 tmr_clr, tmr_en, tmr_term;
   logic [CNT_W-1:0]     tmr_term_val;
   logic                 rise;

   assign rise = btn_level & ~prev_q;

   // One timer serves both timed states; the terminal follows the current state.
   assign tmr_term_val = (state_q == ST_PRESSED) ? CNT_W'(LONG_TICKS) : CNT_W'(DBL_GAP_TICKS);

   press_timer #(.CNT_W(CNT_W)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .term_val_i(tmr_term_val),
      .term_o    (tmr_term)
   );

   always_comb begin
      state_d  = state_q;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      tmr_clr  = 1'b0;
      tmr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_PRESSED;
               tmr_clr = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!btn_level) begin
               state_d = ST_WAIT_GAP;
               tmr_clr = 1'b1;
            end else if (tmr_term) begin
               long_d  = 1'b1;
               state_d = ST_LONG_HELD;
               tmr_clr = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_WAIT_GAP: begin
            if (btn_level) begin
               double_d = 1'b1;
               state_d  = ST_SECOND_HELD;
               tmr_clr  = 1'b1;
            end else if (tmr_term) begin
               short_d = 1'b1;
               state_d = ST_IDLE;
               tmr_clr = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_SECOND_HELD, ST_LONG_HELD: begin
            if (!btn_level) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tmr_clr = 1'b1;
         end
      endcase
      cnt_d = cnt_q;
      if (short_d || double_d || long_d) begin
         cnt_d = cnt_q + EVT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      prev_q <= btn_level;
      if (reset) begin
         state_q  <= ST_IDLE;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         busy_q   <= (state_d != ST_IDLE);
         cnt_q    <= cnt_d;
      end
   end

   assign short_press  = short_q;
   assign double_press = double_q;
   assign long_press   = long_q;
   assign busy         = busy_q;
   assign event_cnt    = cnt_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed and randomized gesture stimulus for button_press_classifier, checked
// every cycle against a timestamp-based gesture model.
module tb_button_press_classifier;
   import button_press_classifier_pkg::*;

   localparam int LT = 8;
   localparam int GT = 4;

   logic       clk;
   logic       reset;
   logic       btn_level;
   logic       short_press, double_press, long_press, busy;
   logic [7:0] event_cnt;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;

   // Model: phase 0 idle, 1 first press held, 2 release gap, 3 wait for release.
   int         phase = 0;
   int         t0 = 0;
   int         n = 0;
   logic       m_prev = 1'b0;
   logic       e_s, e_d, e_l, e_busy;
   logic [7:0] e_cnt = 8'd0;

   button_press_classifier #(.LONG_TICKS(LT), .DBL_GAP_TICKS(GT), .CNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_level   (btn_level),
      .short_press (short_press),
      .double_press(double_press),
      .long_press  (long_press),
      .busy        (busy),
      .event_cnt   (event_cnt),
      .dbg_state   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
      end
   endtask

   task automatic step(input logic b, input logic r);
      btn_level = b;
      reset     = r;
      @(posedge clk);
      n++;
      e_s = 1'b0;
      e_d = 1'b0;
      e_l = 1'b0;
      if (r) begin
         phase = 0;
         e_cnt = 8'd0;
      end else begin
         case (phase)
            0: if (b && !m_prev) begin phase = 1; t0 = n; end
            1: begin
               if (!b) begin
                  phase = 2;
                  t0 = n;
               end else if (n - t0 == LT) begin
                  e_l = 1'b1;
                  phase = 3;
               end
            end
            2: begin
               if (b) begin
                  e_d = 1'b1;
                  phase = 3;
               end else if (n - t0 == GT) begin
                  e_s = 1'b1;
                  phase = 0;
               end
            end
            default: if (!b) phase = 0;
         endcase
         if (e_s || e_d || e_l) e_cnt = e_cnt + 8'd1;
      end
      m_prev = b;
      e_busy = (phase != 0);
      #1;
      check("short_press", {7'd0, short_press}, {7'd0, e_s});
      check("double_press", {7'd0, double_press}, {7'd0, e_d});
      check("long_press", {7'd0, long_press}, {7'd0, e_l});
      check("busy", {7'd0, busy}, {7'd0, e_busy});
      check("event_cnt", event_cnt, e_cnt);
   endtask

   task automatic press(input int hi, input int lo);
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   initial begin
      btn_level = 1'b0;
      reset     = 1'b1;
      do_reset();
      check("reset_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
      check("reset_cnt", event_cnt, 8'd0);

      // 1: short press
      press(4, 6);
      check("t1_cnt", event_cnt, 8'd1);

      // 2: long press, release emits nothing further
      do_reset();
      press(12, 4);
      check("t2_cnt", event_cnt, 8'd1);
      check("t2_busy", {7'd0, busy}, 8'd0);

      // 3: double press
      do_reset();
      press(2, 2);
      press(2, 6);
      check("t3_cnt", event_cnt, 8'd1);

      // 4: second rise exactly at F+3, then release exactly at R+7
      do_reset();
      press(3, 3);
      press(2, 6);
      check("t4a_cnt", event_cnt, 8'd1);
      do_reset();
      press(7, 6);
      check("t4b_cnt", event_cnt, 8'd1);

      // 5: held through reset, then reset mid-press
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
      check("t5_held_cnt", event_cnt, 8'd0);
      press(0, 3);
      press(4, 6);
      check("t5_fresh_cnt", event_cnt, 8'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("t5_mid_busy", {7'd0, busy}, 8'd0);
      check("t5_mid_cnt", event_cnt, 8'd0);
      press(6, 6);
      check("t5_after_cnt", event_cnt, 8'd0);

      // 6: 256 back-to-back shorts wrap the counter
      do_reset();
      for (int k = 0; k < 255; k++) press(2, 5);
      check("t6_cnt_255", event_cnt, 8'd255);
      press(2, 5);
      check("t6_cnt_wrap", event_cnt, 8'd0);

      // Random gestures with occasional reset
      for (int g = 0; g < 60; g++) begin
         if ($urandom_range(0, 15) == 0) step(1'($urandom_range(0, 1)), 1'b1);
         press(int'($urandom_range(1, 12)), int'($urandom_range(1, 7)));
      end
      press(0, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
